// File: rtl/rvvi_trace_pkg.sv
// Shared types and defaults for the RVVI trace capture block.
// trace_rec_t describes the out_rec layout at the default ILEN/XLEN.
package rvvi_trace_pkg;

    localparam int unsigned ILEN_DEFAULT  = 32;
    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned DEPTH_DEFAULT = 8;

    typedef enum logic {
        StSync,
        StTrack
    } ord_state_e;

    typedef struct packed {
        logic [63:0]             order;
        logic [XLEN_DEFAULT-1:0] pc;
        logic [ILEN_DEFAULT-1:0] insn;
        logic                    trap;
        logic [1:0]              mode;
        logic [4:0]              rd;
        logic                    rd_we;
        logic [XLEN_DEFAULT-1:0] rd_data;
    } trace_rec_t;

endpackage

// File: rtl/rvvi_trace_fifo.sv
// Synchronous FIFO with occupancy count; pushes are refused when full unless
// a pop happens in the same cycle.
module rvvi_trace_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (PtrW + 1)'(Depth));
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + (PtrW + 1)'(1);
        else if (!do_push && do_pop) cnt_d = cnt_q - (PtrW + 1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/rvvi_trace_capture.sv
// Captures RVVI retire events into trace records, checks order continuity and
// writeback flags, and buffers records in a FIFO for a ready/valid consumer.
module rvvi_trace_capture
    import rvvi_trace_pkg::*;
#(
    parameter int unsigned ILEN  = ILEN_DEFAULT,
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned RecW = 73 + ILEN + 2 * XLEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tr_valid,
    input  logic [63:0]            tr_order,
    input  logic [ILEN-1:0]        tr_insn,
    input  logic                   tr_trap,
    input  logic [XLEN-1:0]        tr_pc,
    input  logic [1:0]             tr_mode,
    input  logic [31:0]            tr_x_wb,
    input  logic [32*XLEN-1:0]     tr_x_wdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [RecW-1:0]        out_rec,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            drop_cnt,
    output logic                   order_err,
    output logic                   wb_err
);

    logic [4:0]      rd_idx;
    logic            rd_we;
    logic [XLEN-1:0] rd_data;
    logic            multi_wb;

    logic            cap_vld_q, cap_vld_d;
    logic [RecW-1:0] cap_rec_q, cap_rec_d;
    ord_state_e      state_q, state_d;
    logic [63:0]     exp_q, exp_d;
    logic            order_err_q, order_err_d;
    logic            wb_err_q, wb_err_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;

    logic            fifo_full, fifo_empty, pop, drop;

    // Descending scan so the lowest set flag wins.
    always_comb begin
        rd_idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (tr_x_wb[i]) rd_idx = 5'(i);
        end
    end

    assign rd_we    = |tr_x_wb;
    assign rd_data  = rd_we ? tr_x_wdata[rd_idx*XLEN +: XLEN] : '0;
    assign multi_wb = (tr_x_wb & (tr_x_wb - 32'd1)) != 32'd0;

    assign cap_vld_d = tr_valid;
    assign cap_rec_d = tr_valid ? {tr_order, tr_pc, tr_insn, tr_trap, tr_mode,
                                   rd_idx, rd_we, rd_data} : cap_rec_q;

    // On a match tr_order + 1 equals exp + 1, so one update covers both paths.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        order_err_d = order_err_q;
        if (tr_valid) begin
            exp_d = tr_order + 64'd1;
            unique case (state_q)
                StSync:  state_d = StTrack;
                StTrack: if (tr_order != exp_q) order_err_d = 1'b1;
                default: state_d = StSync;
            endcase
        end
    end

    assign wb_err_d   = wb_err_q | (tr_valid & multi_wb);
    assign pop        = out_valid & out_ready;
    assign drop       = cap_vld_q & fifo_full & ~pop;
    assign drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld_q   <= 1'b0;
            state_q     <= StSync;
            exp_q       <= '0;
            order_err_q <= 1'b0;
            wb_err_q    <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            cap_vld_q   <= cap_vld_d;
            state_q     <= state_d;
            exp_q       <= exp_d;
            order_err_q <= order_err_d;
            wb_err_q    <= wb_err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        cap_rec_q <= cap_rec_d;
    end

    rvvi_trace_fifo #(
        .Width (RecW),
        .Depth (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap_vld_q),
        .wdata (cap_rec_q),
        .pop   (pop),
        .rdata (out_rec),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign out_valid = ~fifo_empty;
    assign drop_cnt  = drop_cnt_q;
    assign order_err = order_err_q;
    assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_rvvi_trace_capture.sv
// Randomized bench for rvvi_trace_capture: a queue-based reference model is
// compared every cycle, and directed scenarios pin the model with literals.
module tb_rvvi_trace_capture;
    import rvvi_trace_pkg::*;

    localparam int unsigned ILEN  = 32;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned RecW  = 73 + ILEN + 2 * XLEN;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   tr_valid = 1'b0;
    logic [63:0]            tr_order = '0;
    logic [ILEN-1:0]        tr_insn = '0;
    logic                   tr_trap = 1'b0;
    logic [XLEN-1:0]        tr_pc = '0;
    logic [1:0]             tr_mode = '0;
    logic [31:0]            tr_x_wb = '0;
    logic [32*XLEN-1:0]     tr_x_wdata = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [RecW-1:0]        out_rec;
    logic [$clog2(DEPTH):0] level;
    logic [15:0]            drop_cnt;
    logic                   order_err;
    logic                   wb_err;

    trace_rec_t head;
    assign head = out_rec;

    rvvi_trace_capture #(
        .ILEN  (ILEN),
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tr_valid   (tr_valid),
        .tr_order   (tr_order),
        .tr_insn    (tr_insn),
        .tr_trap    (tr_trap),
        .tr_pc      (tr_pc),
        .tr_mode    (tr_mode),
        .tr_x_wb    (tr_x_wb),
        .tr_x_wdata (tr_x_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rec    (out_rec),
        .level      (level),
        .drop_cnt   (drop_cnt),
        .order_err  (order_err),
        .wb_err     (wb_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Reference model: one pending capture slot feeding a bounded queue.
    trace_rec_t  mq[$];
    trace_rec_t  pend;
    bit          pend_v;
    bit          m_synced, m_oerr, m_werr;
    logic [63:0] m_exp;
    logic [15:0] m_drop;
    int          m_sz;
    bit          m_pop;

    function automatic void model_clear();
        mq.delete();
        pend_v   = 0;
        m_synced = 0;
        m_oerr   = 0;
        m_werr   = 0;
        m_exp    = '0;
        m_drop   = '0;
    endfunction

    function automatic trace_rec_t mk_rec();
        trace_rec_t r;
        r.order   = tr_order;
        r.pc      = tr_pc;
        r.insn    = tr_insn;
        r.trap    = tr_trap;
        r.mode    = tr_mode;
        r.rd      = '0;
        r.rd_we   = (tr_x_wb != 0);
        r.rd_data = '0;
        for (int i = 0; i < 32; i++) begin
            if (tr_x_wb[i]) begin
                r.rd = 5'(i);
                break;
            end
        end
        if (r.rd_we) r.rd_data = XLEN'(tr_x_wdata >> (int'(r.rd) * XLEN));
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            m_sz  = mq.size();
            m_pop = (m_sz != 0) && out_ready;
            if (m_pop) void'(mq.pop_front());
            if (pend_v) begin
                if (m_sz < DEPTH || m_pop) mq.push_back(pend);
                else if (m_drop != 16'hFFFF) m_drop++;
            end
            pend_v = tr_valid;
            if (tr_valid) begin
                pend = mk_rec();
                if (m_synced && tr_order != m_exp) m_oerr = 1;
                m_synced = 1;
                m_exp    = tr_order + 64'd1;
                if ($countones(tr_x_wb) > 1) m_werr = 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("out_valid", 192'(out_valid), 192'(mq.size() != 0));
        chk("level", 192'(level), 192'(mq.size()));
        chk("drop_cnt", 192'(drop_cnt), 192'(m_drop));
        chk("order_err", 192'(order_err), 192'(m_oerr));
        chk("wb_err", 192'(wb_err), 192'(m_werr));
        if (mq.size() != 0) chk("out_rec", 192'(out_rec), 192'(mq[0]));
    end

    function automatic logic [32*XLEN-1:0] rand_wd();
        logic [32*XLEN-1:0] w;
        for (int i = 0; i < 32; i++) w[i*XLEN +: XLEN] = $urandom;
        return w;
    endfunction

    function automatic logic [31:0] rand_wb();
        logic [31:0] w;
        case ($urandom_range(0, 3))
            0: w = '0;
            1: w = 32'd1 << $urandom_range(0, 31);
            2: w = $urandom;
            default: w = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
        endcase
        return w;
    endfunction

    task automatic send(input logic [63:0] o, input logic [31:0] wb,
                        input logic [32*XLEN-1:0] wd);
        tr_valid   = 1'b1;
        tr_order   = o;
        tr_insn    = $urandom;
        tr_pc      = $urandom;
        tr_mode    = 2'($urandom);
        tr_trap    = 1'($urandom);
        tr_x_wb    = wb;
        tr_x_wdata = wd;
        @(negedge clk);
        tr_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [32*XLEN-1:0] wd;
    logic [63:0]        nxt;

    initial begin
        model_clear();
        idle(3);
        chk("rst_out_valid", 192'(out_valid), 192'(0));
        chk("rst_level", 192'(level), 192'(0));
        chk("rst_drop", 192'(drop_cnt), 192'(0));
        rst_n = 1'b1;
        idle(1);

        // In-order events, two-cycle latency.
        out_ready = 1'b1;
        send(5, rand_wb(), rand_wd());
        chk("lat_1cyc", 192'(out_valid), 192'(0));
        send(6, rand_wb(), rand_wd());
        chk("lat_2cyc", 192'(out_valid), 192'(1));
        chk("lat_order5", 192'(head.order), 192'(5));
        send(7, 32'h0, rand_wd());
        chk("seq_head6", 192'(head.order), 192'(6));
        idle(3);
        chk("seq_no_oerr", 192'(order_err), 192'(0));

        // Order gap 10 -> 12, then 13 continues cleanly.
        pulse_reset();
        send(10, 32'h0, rand_wd());
        chk("sync_no_oerr", 192'(order_err), 192'(0));
        send(12, 32'h0, rand_wd());
        chk("gap_oerr", 192'(order_err), 192'(1));
        send(13, 32'h0, rand_wd());
        idle(3);
        chk("gap_sticky", 192'(order_err), 192'(1));

        // Two writeback flags: lowest index wins, wb_err raised.
        out_ready = 1'b0;
        wd = rand_wd();
        wd[1*XLEN +: XLEN] = 32'hCAFE_0001;
        send(14, 32'h0000_0006, wd);
        idle(1);
        chk("wb_rd", 192'(head.rd), 192'(1));
        chk("wb_rd_we", 192'(head.rd_we), 192'(1));
        chk("wb_rd_data", 192'(head.rd_data), 192'(32'hCAFE_0001));
        chk("wb_err", 192'(wb_err), 192'(1));
        out_ready = 1'b1;
        idle(3);

        // Overflow: DEPTH + 3 events with the consumer stalled.
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH + 3; k++) send(64'(15 + k), rand_wb(), rand_wd());
        idle(2);
        chk("ovf_level", 192'(level), 192'(DEPTH));
        chk("ovf_drop", 192'(drop_cnt), 192'(3));
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            chk("drain_order", 192'(head.order), 192'(15 + k));
            @(negedge clk);
        end
        chk("drain_empty", 192'(out_valid), 192'(0));

        // Push and pop together while full.
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) send(64'(26 + k), rand_wb(), rand_wd());
        idle(2);
        chk("full_level", 192'(level), 192'(DEPTH));
        send(34, rand_wb(), rand_wd());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pp_level", 192'(level), 192'(DEPTH));
        chk("pp_drop", 192'(drop_cnt), 192'(3));
        chk("pp_head", 192'(head.order), 192'(27));
        out_ready = 1'b1;
        idle(DEPTH + 4);

        // Reset with four records buffered.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(64'(35 + k), rand_wb(), rand_wd());
        idle(2);
        chk("pre_rst_level", 192'(level), 192'(4));
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("mid_rst_valid", 192'(out_valid), 192'(0));
        chk("mid_rst_level", 192'(level), 192'(0));
        chk("mid_rst_oerr", 192'(order_err), 192'(0));
        @(negedge clk);
        rst_n = 1'b1;
        send(100, 32'h0, rand_wd());
        send(101, 32'h0, rand_wd());
        idle(2);
        chk("post_rst_oerr", 192'(order_err), 192'(0));
        chk("post_rst_level", 192'(level), 192'(2));

        // Random traffic with occasional order jumps and resets.
        nxt = 102;
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 99) < 55);
            if ($urandom_range(0, 999) < 3) begin
                pulse_reset();
            end else if ($urandom_range(0, 99) < 60) begin
                if ($urandom_range(0, 99) < 5) nxt = {$urandom, $urandom};
                send(nxt, rand_wb(), rand_wd());
                nxt = nxt + 64'd1;
            end else begin
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        idle(DEPTH + 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
